// File: rtl/spatial_window_generator_pkg.sv
// Shared constants, window indexing and FSM states for the
// 3x3 spatial-filter datapath (window generator, convolvers).
package spatial_window_generator_pkg;

  localparam int IMG_WIDTH      = 512;
  localparam int PIXEL_SIZE     = 8;
  localparam int WIN_PIXEL_SIZE = 32;
  localparam int NUM_LINES      = 4;

  localparam int WIN_ROWS  = 3;
  localparam int WIN_COLS  = 3;
  localparam int WIN_ELEMS = WIN_ROWS * WIN_COLS;

  localparam int K_TL = 0;
  localparam int K_TC = 1;
  localparam int K_TR = 2;
  localparam int K_ML = 3;
  localparam int K_MC = 4;
  localparam int K_MR = 5;
  localparam int K_BL = 6;
  localparam int K_BC = 7;
  localparam int K_BR = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } swg_state_e;

  // Row 0 is the oldest line, col 0 the leftmost pixel.
  function automatic int win_idx(input int row, input int col);
    return row * WIN_COLS + col;
  endfunction

endpackage

// File: rtl/spatial_window_generator_if.sv
// Pixel-in / window-out bundle of the spatial window generator.
// slave is the generator side, master the stream source/sink.
interface spatial_window_generator_if #(
  parameter int PIXEL_SIZE     =
    spatial_window_generator_pkg::PIXEL_SIZE,
  parameter int WIN_PIXEL_SIZE =
    spatial_window_generator_pkg::WIN_PIXEL_SIZE
);

  logic [PIXEL_SIZE-1:0]       i_pixel_data;
  logic                        i_pixel_data_valid;
  logic [9*WIN_PIXEL_SIZE-1:0] o_pixel_data;
  logic                        o_pixel_data_valid;
  logic                        o_intr;

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_intr
  );

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_intr
  );

endinterface

// File: rtl/spatial_window_generator_line_buffer.sv
// One image line: single write port, three adjacent pixels read
// combinationally starting at i_rd_col. Contents survive reset.
module spatial_window_generator_line_buffer #(
  parameter int IMG_WIDTH  = 512,
  parameter int PIXEL_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [$clog2(IMG_WIDTH)-1:0] i_wr_col,
  input  logic [PIXEL_SIZE-1:0]        i_wr_data,
  input  logic [$clog2(IMG_WIDTH)-1:0] i_rd_col,
  output logic [3*PIXEL_SIZE-1:0]      o_rd_data
);

  localparam int COL_W = $clog2(IMG_WIDTH);

  logic [PIXEL_SIZE-1:0] mem_q [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_col] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int c = 0; c < 3; c++) begin
      o_rd_data[c*PIXEL_SIZE +: PIXEL_SIZE] =
        mem_q[i_rd_col + COL_W'(c)];
    end
  end

endmodule

// File: rtl/spatial_window_generator.sv
// Raster stream -> four rotating line buffers -> one registered
// 3x3 window per cycle, with a pulse for every retired line.
module spatial_window_generator #(
  parameter int IMG_WIDTH      =
    spatial_window_generator_pkg::IMG_WIDTH,
  parameter int PIXEL_SIZE     =
    spatial_window_generator_pkg::PIXEL_SIZE,
  parameter int WIN_PIXEL_SIZE =
    spatial_window_generator_pkg::WIN_PIXEL_SIZE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  spatial_window_generator_if.slave  bus
);

  import spatial_window_generator_pkg::*;

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int CNT_W = $clog2(4*IMG_WIDTH) + 1;
  localparam int LB_W  = 3 * PIXEL_SIZE;
  localparam int WIN_W = WIN_ELEMS * WIN_PIXEL_SIZE;

  swg_state_e       state_q, state_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [1:0]       wr_sel_q, wr_sel_d;
  logic [1:0]       rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [WIN_W-1:0] win_q, win_d, win_mux;
  logic             valid_q, valid_d;
  logic             intr_q, intr_d;
  logic             retire;
  logic             in_valid;
  logic [LB_W-1:0]  lb_rd [NUM_LINES];

  assign in_valid = bus.i_pixel_data_valid;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_lb
    spatial_window_generator_line_buffer #(
      .IMG_WIDTH  (IMG_WIDTH),
      .PIXEL_SIZE (PIXEL_SIZE)
    ) u_lb (
      .clk       (clk),
      .i_wr_en   (in_valid && (wr_sel_q == 2'(i))),
      .i_wr_col  (wr_col_q),
      .i_wr_data (bus.i_pixel_data),
      .i_rd_col  (rd_col_q),
      .o_rd_data (lb_rd[i])
    );
  end

  // Row r of the window comes from line rd_sel+r, wrapping mod 4.
  always_comb begin
    win_mux = '0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      for (int c = 0; c < WIN_COLS; c++) begin
        win_mux[win_idx(r, c)*WIN_PIXEL_SIZE +: WIN_PIXEL_SIZE] =
          WIN_PIXEL_SIZE'(
            lb_rd[rd_sel_q + 2'(r)][c*PIXEL_SIZE +: PIXEL_SIZE]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_col_d = wr_col_q;
    wr_sel_d = wr_sel_q;
    rd_col_d = rd_col_q;
    rd_sel_d = rd_sel_q;
    win_d    = win_q;
    valid_d  = 1'b0;
    intr_d   = 1'b0;
    retire   = 1'b0;

    if (in_valid) begin
      if (wr_col_q == COL_W'(IMG_WIDTH-1)) begin
        wr_col_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pix_cnt_q >= CNT_W'(3*IMG_WIDTH)) begin
          state_d  = ST_READ;
          rd_col_d = '0;
        end
      end
      ST_READ: begin
        valid_d = 1'b1;
        win_d   = win_mux;
        if (rd_col_q == COL_W'(IMG_WIDTH-3)) begin
          retire   = 1'b1;
          intr_d   = 1'b1;
          rd_sel_d = rd_sel_q + 2'd1;
          state_d  = ST_IDLE;
        end else begin
          rd_col_d = rd_col_q + COL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write and a retire in the same cycle net to 1-IMG_WIDTH.
    pix_cnt_d = pix_cnt_q + CNT_W'(in_valid)
              - (retire ? CNT_W'(IMG_WIDTH) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_col_q  <= '0;
      wr_sel_q  <= '0;
      rd_col_q  <= '0;
      rd_sel_q  <= '0;
      pix_cnt_q <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_col_q  <= wr_col_d;
      wr_sel_q  <= wr_sel_d;
      rd_col_q  <= rd_col_d;
      rd_sel_q  <= rd_sel_d;
      pix_cnt_q <= pix_cnt_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      intr_q    <= intr_d;
    end
  end

  assign bus.o_pixel_data       = win_q;
  assign bus.o_pixel_data_valid = valid_q;
  assign bus.o_intr             = intr_q;

endmodule

// File: tb/tb_spatial_window_generator.sv
// Directed bench for spatial_window_generator: a line model pushes
// expected windows per completed line; a monitor pops and compares.
module tb_spatial_window_generator;

  import spatial_window_generator_pkg::*;

  localparam int W   = 8;
  localparam int PS  = 8;
  localparam int WPS = 32;
  localparam int WB  = 9 * WPS;

  typedef struct {
    logic [WB-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   intr_seen = 0;
  int   win_seen = 0;
  exp_t exp_q[$];

  spatial_window_generator_if #(
    .PIXEL_SIZE     (PS),
    .WIN_PIXEL_SIZE (WPS)
  ) bus ();

  spatial_window_generator #(
    .IMG_WIDTH      (W),
    .PIXEL_SIZE     (PS),
    .WIN_PIXEL_SIZE (WPS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [PS-1:0] pix(int row, int col);
    return PS'(row * 16 + col);
  endfunction

  task automatic check(string tag, logic [WB-1:0] obs,
                       logic [WB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completing line `row` (row >= 2) makes one burst due.
  task automatic push_line(int row);
    exp_t e;
    if (row >= 2) begin
      for (int c = 0; c <= W - 3; c++) begin
        e.data = '0;
        for (int r = 0; r < 3; r++) begin
          for (int cc = 0; cc < 3; cc++) begin
            e.data[win_idx(r, cc)*WPS +: WPS] =
              WPS'(pix(row - 2 + r, c + cc));
          end
        end
        e.last = (c == W - 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(int row, int col);
    bus.i_pixel_data       = pix(row, col);
    bus.i_pixel_data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_pixel_data_valid = 1'b0;
    if (col == W - 1) push_line(row);
  endtask

  task automatic send_line(int row, bit gaps);
    for (int c = 0; c < W; c++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send(row, c);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", WB'(exp_q.size()), '0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_pixel_data_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.o_intr === 1'b1) intr_seen++;
    if (bus.o_pixel_data_valid === 1'b1) begin
      win_seen++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL window_expected: observed=window expected=none");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("win_data", bus.o_pixel_data, e.data);
        check("win_intr", WB'(bus.o_intr), WB'(e.last));
      end
    end else begin
      check("intr_idle", WB'(bus.o_intr), '0);
    end
  end

  initial begin
    logic [WB-1:0] fw;
    int vals[9];
    int i0;
    int n;

    vals = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    fw = '0;
    for (int k = 0; k < 9; k++) fw[k*WPS +: WPS] = WPS'(vals[k]);

    // Reset held with valid high: nothing may be counted.
    bus.i_pixel_data       = 8'hAA;
    bus.i_pixel_data_valid = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", WB'(bus.o_pixel_data_valid), '0);
    check("rst_intr", WB'(bus.o_intr), '0);
    check("rst_data", bus.o_pixel_data, '0);
    bus.i_pixel_data_valid = 1'b0;
    reset_n = 1'b1;

    // Fill three lines, then stream line 3 during the first burst.
    i0 = intr_seen;
    send_line(0, 1'b0);
    send_line(1, 1'b0);
    for (int c = 0; c < W; c++) send(2, c);
    send(3, 0);
    check("lat_n1", WB'(bus.o_pixel_data_valid), '0);
    send(3, 1);
    check("lat_n2", WB'(bus.o_pixel_data_valid), WB'(1));
    check("first_win", bus.o_pixel_data, fw);
    for (int c = 2; c < W; c++) send(3, c);
    drain();
    check("intr_fill", WB'(intr_seen - i0), WB'(2));

    // Seven continuous lines: read pointer wraps 3 -> 0.
    do_reset();
    i0 = intr_seen;
    for (int r = 0; r < 7; r++) send_line(r, 1'b0);
    drain();
    check("intr_wrap", WB'(intr_seen - i0), WB'(5));

    // Random idle cycles between pixels.
    do_reset();
    i0 = intr_seen;
    for (int r = 0; r < 4; r++) send_line(r, 1'b1);
    drain();
    check("intr_gap", WB'(intr_seen - i0), WB'(2));

    // Reset on the third window of a burst, then replay.
    do_reset();
    i0 = win_seen;
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    n = 0;
    while (win_seen < i0 + 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_win3", WB'(win_seen - i0), WB'(3));
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_valid", WB'(bus.o_pixel_data_valid), '0);
    check("mid_rst_intr", WB'(bus.o_intr), '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    i0 = intr_seen;
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    drain();
    check("intr_replay", WB'(intr_seen - i0), WB'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
